// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcode count and command type for the ALU issue stage
package alu_pkg;

  localparam int ALU_DATA_W  = 8;
  localparam int ALU_OP_W    = 4;
  localparam int ALU_NUM_OPS = 8;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    logic [ALU_OP_W-1:0]   op;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO with combinational head and occupancy count
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 20,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is data-only; validity is carried entirely by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - FIFO-fed operand issue and result capture around a combinational ALU
// Optional illegal-opcode discard enabled by ALU_ISSUE_OPCODE_CHECK_EN.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = ALU_OP_W,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [OP_W-1:0]   in_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OP_W-1:0]   out_op,
  output logic [CW-1:0]     fifo_count,
  output logic              op_err
);

  localparam int CMD_W = 2 * DATA_W + OP_W;

  logic [CMD_W-1:0]  head;
  logic [DATA_W-1:0] head_a;
  logic [DATA_W-1:0] head_b;
  logic [OP_W-1:0]   head_op;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              adv;
  logic              iss_vld;
  logic              head_bad;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign adv      = !iss_vld || !out_valid || out_ready;
  assign pop      = adv && !fifo_empty;

  assign head_a  = head[CMD_W-1 -: DATA_W];
  assign head_b  = head[OP_W +: DATA_W];
  assign head_op = head[OP_W-1:0];

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({in_a, in_b, in_op}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef ALU_ISSUE_OPCODE_CHECK_EN
  logic op_err_q;

  assign head_bad = (32'(head_op) >= 32'(ALU_NUM_OPS));
  assign op_err   = op_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_err_q <= 1'b0;
    end else begin
      op_err_q <= pop && head_bad;
    end
  end
`else
  assign head_bad = 1'b0;
  assign op_err   = 1'b0;
`endif

  // Operand lines only move on an accepted pop, so the ALU never sees a glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iss_vld <= 1'b0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
    end else if (adv) begin
      if (pop && !head_bad) begin
        iss_vld <= 1'b1;
        alu_a   <= head_a;
        alu_b   <= head_b;
        alu_op  <= head_op;
      end else begin
        iss_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_op    <= '0;
    end else if (adv) begin
      if (iss_vld) begin
        out_valid <= 1'b1;
        out_data  <= alu_out;
        out_op    <= alu_op;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue with an adder stub ALU
module tb_alu_issue;
  import alu_pkg::*;

  localparam int DEPTH = 4;
`ifdef ALU_ISSUE_OPCODE_CHECK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [3:0] in_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_op;
  logic [7:0] alu_out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_op;
  logic [2:0] fifo_count;
  logic       op_err;

  alu_issue #(.DEPTH(DEPTH), .DATA_W(8), .OP_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_out    (alu_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_op     (out_op),
    .fifo_count (fifo_count),
    .op_err     (op_err)
  );

  assign alu_out = alu_a + alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_t   exp_q[$];
  int         checks;
  int         errors;
  int         accept_cnt;
  int         result_cnt;
  int         err_pulses;
  int         exp_errs;
  logic       prev_stall;
  logic [7:0] prev_data;
  logic [3:0] prev_op;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic bit dropped(input logic [3:0] op);
    return OPCHK && (op >= 4'd8);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n && in_valid && in_ready) begin
      accept_cnt++;
      if (dropped(in_op)) exp_errs++;
      else exp_q.push_back('{a: in_a, b: in_b, op: in_op});
    end
  end

  always @(negedge clk) begin
    if (reset_n && op_err) err_pulses++;
  end

  always @(negedge clk) begin
    alu_cmd_t e;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!out_valid || out_data !== prev_data || out_op !== prev_op) begin
          errors++;
          $display("FAIL hold_stable: actual v%0d d%0d o%0d required v1 d%0d o%0d",
                   out_valid, out_data, out_op, prev_data, prev_op);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: actual d%0d o%0d required none", out_data, out_op);
        end else begin
          e = exp_q.pop_front();
          chk("result_data", int'(out_data), (int'(e.a) + int'(e.b)) % 256);
          chk("result_op", int'(out_op), int'(e.op));
          result_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_op    = out_op;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual expired required finish");
    $fatal(1);
  end

  initial begin
    int base;
    int rc;
    int ep;
    int ops[3] = '{7, 9, 2};
    checks = 0; errors = 0; accept_cnt = 0; result_cnt = 0;
    err_pulses = 0; exp_errs = 0; prev_stall = 1'b0;
    reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_op", out_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_op_err", op_err, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single command latency
    tick();
    out_ready = 1'b1; in_valid = 1'b1; in_a = 8'd104; in_b = 8'd200; in_op = 4'd0;
    tick();
    in_valid = 1'b0;
    chk("s1_valid_t", out_valid, 0);
    tick();
    chk("s1_valid_t1", out_valid, 0);
    tick();
    chk("s1_valid_t2", out_valid, 1);
    chk("s1_data", out_data, 48);
    chk("s1_op", out_op, 0);
    repeat (3) tick();

    // Fill with the consumer stalled
    out_ready = 1'b0;
    base = accept_cnt;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_a = 8'($urandom); in_b = 8'($urandom); in_op = 4'($urandom_range(0, 7));
      tick();
    end
    chk("s2_accepts", accept_cnt - base, 6);
    chk("s2_in_ready", in_ready, 0);
    chk("s2_fifo_count", fifo_count, 4);

    // Push against full while draining, then release the whole backlog
    rc = result_cnt;
    out_ready = 1'b1;
    @(negedge clk);
    chk("s4_in_ready_full", in_ready, 0);
    chk("s3_first_valid", out_valid, 1);
    @(posedge clk);
    #1;
    chk("s4_fifo_count", fifo_count, 3);
    chk("s3_in_ready_back", in_ready, 1);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("s3_consecutive_valid", out_valid, 1);
    end
    @(negedge clk);
    chk("s3_valid_after", out_valid, 0);
    tick();
    chk("s3_result_count", result_cnt - rc, 6);

    // Reset with work in every stage
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_a = 8'($urandom); in_b = 8'($urandom); in_op = 4'($urandom_range(0, 7));
      tick();
    end
    in_valid = 1'b0;
    chk("s5_pre_count", fifo_count, 3);
    chk("s5_pre_valid", out_valid, 1);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk("s5_fifo_count", fifo_count, 0);
    chk("s5_in_ready", in_ready, 1);
    chk("s5_out_valid", out_valid, 0);
    chk("s5_out_data", out_data, 0);
    chk("s5_out_op", out_op, 0);
    chk("s5_alu_a", alu_a, 0);
    repeat (2) tick();
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    rc = result_cnt;
    repeat (10) tick();
    chk("s5_no_stale", result_cnt - rc, 0);

    // Opcode check sequence
    rc = result_cnt;
    ep = err_pulses;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 8'd32; in_b = 8'd32; in_op = 4'(ops[i]);
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    chk("s6_results", result_cnt - rc, OPCHK ? 2 : 3);
    chk("s6_op_err_pulses", err_pulses - ep, OPCHK ? 1 : 0);
    chk("s6_queue_empty", exp_q.size(), 0);

    // Random traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_op     = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && fifo_count == 0 && !out_valid) break;
      tick();
    end
    repeat (2) tick();
    chk("rand_drain_empty", exp_q.size(), 0);
    chk("rand_fifo_empty", fifo_count, 0);
    chk("rand_op_err_total", err_pulses, exp_errs);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
